// File: rtl/key_debounce_pkg.sv
// Shared types and helpers for the multi-channel key debouncer.
package key_debounce_pkg;

    // Per-channel debounce state.
    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } key_state_t;

    // Smallest counter width able to hold max(a, b) without wrapping.
    function automatic int cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = 1;
        for (int i = 0; i < 32; i++) begin
            if ((1 << w) <= m) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, four-state debounce FSM,
// registered level/press/release outputs. Long-press detection is built
// only when KEY_DEBOUNCE_LONG_PRESS_EN is defined; otherwise key_long is 0.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int STABLE_CNT = 3,
    parameter int LONG_CNT   = 100,
    parameter int ACTIVE_LOW = 0
) (
    input  logic clk100hz,
    input  logic rst,
    input  logic btn,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int           CW        = cnt_width(STABLE_CNT, LONG_CNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    // Raw pin level that means "not pressed".
    localparam logic          REL_LEVEL = (ACTIVE_LOW != 0);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          sample;
    key_state_t    state_reg;
    key_state_t    state_next;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] cnt_inc;
    logic          level_reg;
    logic          press_reg;
    logic          release_reg;
    logic          enter_held;
    logic          in_pressed;

    // Two-flop synchronizer; reset parks it at the released pin level.
    always_ff @(posedge clk100hz) begin
        if (rst) begin
            sync1_reg <= REL_LEVEL;
            sync2_reg <= REL_LEVEL;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
        end
    end

    // Normalised sample: 1 always means pressed.
    assign sample  = sync2_reg ^ REL_LEVEL;
    assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CW'(1);

    // Debounce state and agreement counter registers.
    always_ff @(posedge clk100hz) begin
        if (rst) begin
            state_reg <= ST_RELEASED;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state: a single sample agreeing with the current level aborts a pending change.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_RELEASED: begin
                if (sample) begin
                    state_next = ST_PRESS_WAIT;
                    cnt_next   = CW'(1);
                end else begin
                    cnt_next   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!sample) begin
                    state_next = ST_RELEASED;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = ST_HELD;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_inc;
                end
            end
            ST_HELD: begin
                if (!sample) begin
                    state_next = ST_RELEASE_WAIT;
                    cnt_next   = CW'(1);
                end else begin
                    cnt_next   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (sample) begin
                    state_next = ST_HELD;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = ST_RELEASED;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_inc;
                end
            end
            default: begin
                state_next = ST_RELEASED;
                cnt_next   = '0;
            end
        endcase
    end

    assign enter_held = (state_reg == ST_PRESS_WAIT) && (state_next == ST_HELD);
    assign in_pressed = (state_reg == ST_HELD) || (state_reg == ST_RELEASE_WAIT);

    // Registered outputs, aligned with the state transition that causes them.
    always_ff @(posedge clk100hz) begin
        if (rst) begin
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
        end else begin
            level_reg   <= (state_next == ST_HELD) || (state_next == ST_RELEASE_WAIT);
            press_reg   <= enter_held;
            release_reg <= (state_reg == ST_RELEASE_WAIT) && (state_next == ST_RELEASED);
        end
    end

    assign key_level   = level_reg;
    assign key_press   = press_reg;
    assign key_release = release_reg;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CNT - 1);

    logic [CW-1:0] hold_reg;
    logic          long_reg;

    // Hold counter restarts only on a fresh press; bounce returns keep counting.
    always_ff @(posedge clk100hz) begin
        if (rst) begin
            hold_reg <= '0;
            long_reg <= 1'b0;
        end else begin
            long_reg <= in_pressed && (state_next != ST_RELEASED) && (hold_reg == LONG_LAST);
            if (enter_held) begin
                hold_reg <= '0;
            end else if (in_pressed && (hold_reg != CNT_MAX)) begin
                hold_reg <= hold_reg + CW'(1);
            end
        end
    end

    assign key_long = long_reg;
`else
    assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_n.sv
// N-channel key debouncer: one independent key_debounce_ch per key.
// Optional long-press pulses are enabled with KEY_DEBOUNCE_LONG_PRESS_EN.
module key_debounce_n
    import key_debounce_pkg::*;
#(
    parameter int N_KEYS     = 4,
    parameter int STABLE_CNT = 3,
    parameter int LONG_CNT   = 100,
    parameter int ACTIVE_LOW = 0
) (
    input  logic              clk100hz,
    input  logic              rst,
    input  logic [N_KEYS-1:0] btn,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_ch
            key_debounce_ch #(
                .STABLE_CNT (STABLE_CNT),
                .LONG_CNT   (LONG_CNT),
                .ACTIVE_LOW (ACTIVE_LOW)
            ) u_ch (
                .clk100hz    (clk100hz),
                .rst         (rst),
                .btn         (btn[gi]),
                .key_level   (key_level[gi]),
                .key_press   (key_press[gi]),
                .key_release (key_release[gi]),
                .key_long    (key_long[gi])
            );
        end
    endgenerate

endmodule
